// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: resolves data-miss,
// redirect, fetch-miss and load-use hazards by priority and keeps perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ID_rs1,
  input  logic [REG_AW-1:0] ID_rs2,
  input  logic              ID_use_rs1,
  input  logic              ID_use_rs2,
  input  logic [REG_AW-1:0] EX_rd,
  input  logic              EX_MemRead,
  input  logic              EX_PCsrc,
  input  logic              imem_ready,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              Stall,
  output logic              StallIFID,
  output logic              StallIDEX,
  output logic              StallEXMEM,
  output logic              FlushIFID,
  output logic              FlushIDEX,
  output logic              FlushMEMWB,
  output logic              abort_fetch,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IF_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_stallCycles;
  logic [CNT_W-1:0] r_flushCount;
  logic             w_loadUse;
  logic             w_dmiss;
  logic             w_imiss;
  logic             w_redirect;

  assign w_loadUse = EX_MemRead && (EX_rd != '0) &&
                     ((ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                      (ID_use_rs2 && (ID_rs2 == EX_rd)));
  assign w_dmiss   = dmem_req && !dmem_ready;
  assign w_imiss   = !imem_ready;

  // Controls depend only on the live condition terms, so a wait state releases
  // in the same cycle its ready arrives; the state register is for observation.
  always_comb begin
    Stall       = 1'b0;
    StallIFID   = 1'b0;
    StallIDEX   = 1'b0;
    StallEXMEM  = 1'b0;
    FlushIFID   = 1'b0;
    FlushIDEX   = 1'b0;
    FlushMEMWB  = 1'b0;
    abort_fetch = 1'b0;
    w_redirect  = 1'b0;
    w_next      = RUN;
    if (rst) begin
      if (w_dmiss) begin
        Stall      = 1'b1;
        StallIFID  = 1'b1;
        StallIDEX  = 1'b1;
        StallEXMEM = 1'b1;
        FlushMEMWB = 1'b1;
        w_next     = MEM_WAIT;
      end else if (EX_PCsrc) begin
        FlushIFID   = 1'b1;
        FlushIDEX   = 1'b1;
        abort_fetch = w_imiss;
        w_redirect  = 1'b1;
      end else if (w_imiss) begin
        Stall     = 1'b1;
        StallIFID = 1'b1;
        FlushIDEX = 1'b1;
        w_next    = IF_WAIT;
      end else if (w_loadUse) begin
        Stall     = 1'b1;
        StallIFID = 1'b1;
        FlushIDEX = 1'b1;
      end
    end
  end

  // State and saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RUN;
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else begin
      r_state <= w_next;
      if (Stall && (r_stallCycles != '1))
        r_stallCycles <= r_stallCycles + 1'b1;
      if (w_redirect && (r_flushCount != '1))
        r_flushCount <= r_flushCount + 1'b1;
    end
  end

  assign state_o      = r_state;
  assign stall_cycles = r_stallCycles;
  assign flush_count  = r_flushCount;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios plus
// randomized traffic compared against a priority-rule reference model.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W  = 16;
  localparam int REG_AW = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] idRs1, idRs2, exRd;
  logic              idUseRs1, idUseRs2, exMemRead, exPcSrc;
  logic              imemReady, dmemReq, dmemReady;
  logic              stall, stallIfId, stallIdEx, stallExMem;
  logic              flushIfId, flushIdEx, flushMemWb, abortFetch;
  logic [1:0]        stateO;
  logic [CNT_W-1:0]  stallCycles, flushCount;

  int checks;
  int failures;
  int mState;
  int mStall;
  int mFlush;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(idRs1), .ID_rs2(idRs2), .ID_use_rs1(idUseRs1), .ID_use_rs2(idUseRs2),
    .EX_rd(exRd), .EX_MemRead(exMemRead), .EX_PCsrc(exPcSrc),
    .imem_ready(imemReady), .dmem_req(dmemReq), .dmem_ready(dmemReady),
    .Stall(stall), .StallIFID(stallIfId), .StallIDEX(stallIdEx), .StallEXMEM(stallExMem),
    .FlushIFID(flushIfId), .FlushIDEX(flushIdEx), .FlushMEMWB(flushMemWb),
    .abort_fetch(abortFetch), .state_o(stateO),
    .stall_cycles(stallCycles), .flush_count(flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] ctrlVec();
    return {stall, stallIfId, stallIdEx, stallExMem,
            flushIfId, flushIdEx, flushMemWb, abortFetch};
  endfunction

  // Drives one cycle of inputs, checks outputs against the rule model, then
  // advances the model across the clock edge.
  task automatic applyStimulus(input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                               input logic u1, input logic u2,
                               input logic [REG_AW-1:0] rd, input logic memRd,
                               input logic pcSrc, input logic iRdy,
                               input logic dReq, input logic dRdy);
    logic       loadUse, dmiss, imiss;
    logic [7:0] expCtrl;
    int         nextState;
    idRs1 = rs1; idRs2 = rs2; idUseRs1 = u1; idUseRs2 = u2;
    exRd = rd; exMemRead = memRd; exPcSrc = pcSrc;
    imemReady = iRdy; dmemReq = dReq; dmemReady = dRdy;
    loadUse = memRd && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    dmiss   = dReq && !dRdy;
    imiss   = !iRdy;
    expCtrl = 8'b0;
    nextState = 0;
    if (dmiss) begin
      expCtrl = 8'b1111_0010;
      nextState = 2;
    end else if (pcSrc) begin
      expCtrl = {7'b0000_110, imiss};
      if (mFlush < CNT_MAX) mFlush = mFlush + 1;
    end else if (imiss) begin
      expCtrl = 8'b1100_0100;
      nextState = 1;
    end else if (loadUse) begin
      expCtrl = 8'b1100_0100;
    end
    #2;
    checkOutput("ctrl", 32'(ctrlVec()), 32'(expCtrl));
    checkOutput("state", 32'(stateO), 32'(mState));
    checkOutput("stallCycles", 32'(stallCycles), 32'(mStall));
    checkOutput("flushCount", 32'(flushCount), 32'(mFlush - ((!dmiss && pcSrc && mFlush > 0) ? 1 : 0)));
    @(posedge clk);
    mState = nextState;
    if (expCtrl[7] && mStall < CNT_MAX) mStall = mStall + 1;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
  endtask

  initial begin
    int flushBefore;
    checks = 0; failures = 0;
    mState = 0; mStall = 0; mFlush = 0;
    rst = 1'b0;
    idRs1 = 0; idRs2 = 0; idUseRs1 = 0; idUseRs2 = 0; exRd = 0;
    exMemRead = 0; exPcSrc = 0; imemReady = 1; dmemReq = 1; dmemReady = 0;
    #3;
    checkOutput("resetCtrl", 32'(ctrlVec()), 32'h0);
    checkOutput("resetState", 32'(stateO), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    idle();

    // Load-use on rs2, then the same with rd=0.
    applyStimulus(0, 5, 0, 1, 5, 1, 0, 1, 0, 1);
    idle();
    applyStimulus(0, 0, 0, 1, 0, 1, 0, 1, 0, 1);

    // Branch wins over load-use.
    flushBefore = mFlush;
    applyStimulus(7, 3, 1, 0, 7, 1, 1, 1, 0, 1);
    checkOutput("branchFlushCount", 32'(flushCount), 32'(flushBefore + 1));

    // Data miss for 3 cycles with a branch held in EX; flush only on release.
    flushBefore = mFlush;
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    checkOutput("dmissState", 32'(stateO), 32'h2);
    checkOutput("dmissFlushHeld", 32'(flushCount), 32'(flushBefore));
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    checkOutput("dmissReleaseFlush", 32'(flushCount), 32'(flushBefore + 1));
    idle();

    // Fetch miss for 2 cycles, then a redirect aborts the fetch.
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("imissState", 32'(stateO), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("abortNextState", 32'(stateO), 32'h0);

    // Simultaneous dmiss and imiss: freeze, then fetch wait.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();

    // Randomized traffic with small register numbers to provoke matches.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom),
                    REG_AW'($urandom_range(0, 3)), 1'($urandom),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) != 0),
                    1'($urandom), 1'($urandom));
    end
    idle();

    // Asynchronous reset in the middle of a freeze.
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    rst = 1'b0;
    #1;
    checkOutput("asyncState", 32'(stateO), 32'h0);
    checkOutput("asyncCtrl", 32'(ctrlVec()), 32'h0);
    checkOutput("asyncStallCnt", 32'(stallCycles), 32'h0);
    checkOutput("asyncFlushCnt", 32'(flushCount), 32'h0);
    mState = 0; mStall = 0; mFlush = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    idle();

    // Saturation of the stall counter through a long fetch wait.
    idRs1 = 0; idRs2 = 0; idUseRs1 = 0; idUseRs2 = 0; exRd = 0;
    exMemRead = 0; exPcSrc = 0; dmemReq = 0; dmemReady = 1; imemReady = 0;
    repeat (70000) @(posedge clk);
    #1;
    mState = 1;
    mStall = CNT_MAX;
    checkOutput("stallSaturate", 32'(stallCycles), 32'hFFFF);
    idle();
    checkOutput("stallHold", 32'(stallCycles), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
